// File: rtl/liteeth_sram_pkg.sv
// Shared types and helpers for the LiteEth 1RW1R SRAM model.
package liteeth_sram_pkg;

  // Post-reset array-clear state machine states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Upper bounds for the generic mask helper; callers cast the result
  // down to their own data width.
  localparam int SRAM_MAX_BITS  = 256;
  localparam int SRAM_MAX_LANES = 256;

  // Number of write-mask lanes in a data word.
  function automatic int lane_count(input int bits, input int gran);
    return bits / gran;
  endfunction

  // Expand a per-lane write mask into a per-bit mask: data bit b is
  // controlled by lane b/gran.
  function automatic logic [SRAM_MAX_BITS-1:0] mask_expand(
    input logic [SRAM_MAX_LANES-1:0] lane_mask,
    input int                        gran
  );
    logic [SRAM_MAX_BITS-1:0] bit_mask;
    bit_mask = '0;
    for (int b = 0; b < SRAM_MAX_BITS; b++) begin
      bit_mask[b] = lane_mask[b / gran];
    end
    return bit_mask;
  endfunction

endpackage

// File: rtl/liteeth_sram_rd_pipe.sv
// Read-side delay line: carries {data, valid, collision} through LAT
// register stages. Data stages only load when a read is travelling through
// them, so the output holds its last value between reads.
module liteeth_sram_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk0,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_coll,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_coll
);

  logic [LAT-1:0]        valid_reg;
  logic [LAT-1:0]        coll_reg;
  logic [LAT-1:0][W-1:0] data_reg;

  // Shift valid/collision every cycle; advance data only alongside a valid.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      coll_reg  <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      coll_reg[0]  <= in_valid & in_coll;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int s = 1; s < LAT; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        coll_reg[s]  <= coll_reg[s-1];
        if (valid_reg[s-1]) begin
          data_reg[s] <= data_reg[s-1];
        end
      end
    end
  end

  assign out_data  = data_reg[LAT-1];
  assign out_valid = valid_reg[LAT-1];
  assign out_coll  = coll_reg[LAT-1];

endmodule

// File: rtl/liteeth_1rw1r_sram_gen.sv
// Behavioural 1RW1R SRAM for LiteEth buffers: lane-masked read-first RW
// port, read-only R port, optional same-cycle write forwarding to R,
// configurable read latency and a post-reset clear of the whole array.
module liteeth_1rw1r_sram_gen
  import liteeth_sram_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int WORD_DEPTH    = 384,
  parameter int ADDR_WIDTH    = 9,
  parameter int MASK_GRAN     = 8,
  parameter int RD_LATENCY    = 1,
  parameter int RD_BYPASS     = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                      clk0,
  input  logic                      rst_n,
  output logic                      init_busy,
  input  logic                      ce_rw1,
  input  logic                      we_in_rw1,
  input  logic [BITS/MASK_GRAN-1:0] w_mask_rw1,
  input  logic [ADDR_WIDTH-1:0]     addr_rw1,
  input  logic [BITS-1:0]           wd_in_rw1,
  output logic [BITS-1:0]           rd_out_rw1,
  output logic                      rd_valid_rw1,
  input  logic                      ce_r1,
  input  logic [ADDR_WIDTH-1:0]     addr_r1,
  output logic [BITS-1:0]           rd_out_r1,
  output logic                      rd_valid_r1,
  output logic                      collision
);

  localparam int                    LANES     = lane_count(BITS, MASK_GRAN);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [BITS-1:0] mem [WORD_DEPTH];

  clr_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;

  logic                  rw_acc, r_acc, rw_in_range, r_in_range;
  logic                  wr_do, coll_now;
  logic [BITS-1:0]       bit_mask, old_rw, old_r, merged, r_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BITS-1:0]       wr_data;
  logic [LANES-1:0]      lane_we;
  logic                  rw_coll_unused_zero, r_coll;

  // Clear FSM state and word counter.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Clear FSM: walk every word once, then release the ports.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    init_busy    = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        init_busy    = 1'b1;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request qualification; out-of-range addresses read as zero.
  assign rw_acc      = ce_rw1 & ~init_busy;
  assign r_acc       = ce_r1 & ~init_busy;
  assign rw_in_range = {1'b0, addr_rw1} < DEPTH_EXT;
  assign r_in_range  = {1'b0, addr_r1} < DEPTH_EXT;
  assign wr_do       = rw_acc & we_in_rw1 & rw_in_range;
  assign coll_now    = wr_do & r_acc & r_in_range & (addr_rw1 == addr_r1);

  assign bit_mask = BITS'(mask_expand(SRAM_MAX_LANES'(w_mask_rw1), MASK_GRAN));
  assign old_rw   = rw_in_range ? mem[addr_rw1] : '0;
  assign old_r    = r_in_range ? mem[addr_r1] : '0;
  assign merged   = (old_rw & ~bit_mask) | (wd_in_rw1 & bit_mask);
  assign r_data   = (coll_now && (RD_BYPASS != 0)) ? merged : old_r;

  // Single write port shared by the clear walk and port RW.
  always_comb begin
    wr_addr = addr_rw1;
    wr_data = wd_in_rw1;
    lane_we = '0;
    if (init_busy) begin
      wr_addr = clr_cnt_reg;
      wr_data = '0;
      lane_we = '1;
    end else if (wr_do) begin
      lane_we = w_mask_rw1;
    end
  end

  // Lane-enabled array write; array contents are never reset directly.
  always_ff @(posedge clk0) begin
    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) begin
        mem[wr_addr][k*MASK_GRAN +: MASK_GRAN] <= wr_data[k*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  liteeth_sram_rd_pipe #(
    .W   (BITS),
    .LAT (RD_LATENCY)
  ) u_pipe_rw (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .in_valid  (rw_acc),
    .in_data   (old_rw),
    .in_coll   (1'b0),
    .out_data  (rd_out_rw1),
    .out_valid (rd_valid_rw1),
    .out_coll  (rw_coll_unused_zero)
  );

  liteeth_sram_rd_pipe #(
    .W   (BITS),
    .LAT (RD_LATENCY)
  ) u_pipe_r (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .in_valid  (r_acc),
    .in_data   (r_data),
    .in_coll   (coll_now),
    .out_data  (rd_out_r1),
    .out_valid (rd_valid_r1),
    .out_coll  (r_coll)
  );

  // The RW pipe never carries a collision; OR-ing it keeps both pipes wired alike.
  assign collision = r_coll | rw_coll_unused_zero;

endmodule
